// File: rtl/mux_lectura_puertos_pkg.sv
// rtl/mux_lectura_puertos_pkg.sv - shared port map, button codes and interrupt state encoding
package mux_lectura_puertos_pkg;

  // Port map shared by the read mux and the writer-side output decoder
  localparam logic [7:0] PUERTO_SWITCH   = 8'h01;
  localparam logic [7:0] PUERTO_SALIDA_A = 8'h10;
  localparam logic [7:0] PUERTO_SALIDA_B = 8'h11;
  localparam logic [7:0] PUERTO_SALIDA_C = 8'h20;
  localparam logic [7:0] PUERTO_SALIDA_D = 8'h21;
  localparam logic [7:0] PUERTO_BOTONES  = 8'h22;
  localparam logic [7:0] PUERTO_ESTADO   = 8'h30;
  localparam logic [7:0] PUERTO_RTC      = 8'h31;

  localparam logic [7:0] COD_NINGUNO = 8'h00;
  localparam logic [7:0] COD_BOTON3  = 8'h01;
  localparam logic [7:0] COD_BOTON2  = 8'h02;
  localparam logic [7:0] COD_BOTON1  = 8'h03;
  localparam logic [7:0] COD_BOTON0  = 8'h04;

  // Sticky flag vector layout: buttons in [3:0], then alarm and stopwatch
  localparam int N_BOTONES  = 4;
  localparam int IDX_ALARMA = 4;
  localparam int IDX_CRONO  = 5;
  localparam int N_BANDERAS = 6;
  localparam logic [N_BANDERAS-1:0] MASCARA_IRQ = 6'b11_0000;

  typedef enum logic {
    INACTIVO  = 1'b0,
    PENDIENTE = 1'b1
  } estado_irq_t;

  function automatic logic [7:0] codigo_boton(input logic [N_BOTONES-1:0] banderas);
    logic [7:0] codigo;
    if (banderas[3])      codigo = COD_BOTON3;
    else if (banderas[2]) codigo = COD_BOTON2;
    else if (banderas[1]) codigo = COD_BOTON1;
    else if (banderas[0]) codigo = COD_BOTON0;
    else                  codigo = COD_NINGUNO;
    return codigo;
  endfunction

  function automatic logic [N_BOTONES-1:0] boton_de_codigo(input logic [7:0] codigo);
    logic [N_BOTONES-1:0] mascara;
    case (codigo)
      COD_BOTON3: mascara = 4'b1000;
      COD_BOTON2: mascara = 4'b0100;
      COD_BOTON1: mascara = 4'b0010;
      COD_BOTON0: mascara = 4'b0001;
      default:    mascara = 4'b0000;
    endcase
    return mascara;
  endfunction

endpackage

// File: rtl/mux_lectura_puertos_if.sv
// rtl/mux_lectura_puertos_if.sv - PicoBlaze input-port and interrupt bus
interface mux_lectura_puertos_if #(
  parameter int ANCHO_DATO = 8
);
  logic [ANCHO_DATO-1:0] port_id;
  logic                  read_strobe;
  logic                  interrupt_ack;
  logic [ANCHO_DATO-1:0] in_port;
  logic                  interrupt;

  modport master (
    output port_id,
    output read_strobe,
    output interrupt_ack,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  port_id,
    input  read_strobe,
    input  interrupt_ack,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/bandera_pegajosa.sv
// rtl/bandera_pegajosa.sv - rising-edge sticky flag with clear-on-read, set wins
module bandera_pegajosa (
  input  logic reloj,
  input  logic resetM,
  input  logic senal,
  input  logic limpiar,
  output logic bandera,
  output logic flanco
);

  logic previo;

  assign flanco = senal & ~previo;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      previo  <= 1'b0;
      bandera <= 1'b0;
    end else begin
      previo <= senal;
      if (flanco) begin
        bandera <= 1'b1;
      end else if (limpiar) begin
        bandera <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_lectura_puertos.sv
// rtl/mux_lectura_puertos.sv - PicoBlaze input-port mux with sticky event flags and interrupt
module mux_lectura_puertos #(
  parameter int ANCHO_DATO = 8
) (
  input  logic                  reloj,
  input  logic                  resetM,
  mux_lectura_puertos_if.slave  bus,
  input  logic [3:0]            botones_in,
  input  logic [1:0]            switch_in,
  input  logic                  alarma,
  input  logic                  fin_crono,
  input  logic [ANCHO_DATO-1:0] dato_rtc,
  input  logic                  rtc_listo
);
  import mux_lectura_puertos_pkg::*;

  logic [1:0]            sw_m;
  logic [1:0]            sw_s;
  logic [7:0]            dir;
  logic                  lee_bot;
  logic                  lee_est;
  logic                  lee_rtc;
  logic [N_BANDERAS-1:0] eventos;
  logic [N_BANDERAS-1:0] limpiar;
  logic [N_BANDERAS-1:0] banderas;
  logic [N_BANDERAS-1:0] flancos;
  logic [ANCHO_DATO-1:0] rtc_buf;
  logic                  rtc_valid;
  logic                  ovr;
  logic [ANCHO_DATO-1:0] lectura;
  logic                  irq_evento;
  estado_irq_t           estado;
  estado_irq_t           estado_sig;

  assign dir     = 8'(bus.port_id);
  assign lee_bot = bus.read_strobe && (dir == PUERTO_BOTONES);
  assign lee_est = bus.read_strobe && (dir == PUERTO_ESTADO);
  assign lee_rtc = bus.read_strobe && (dir == PUERTO_RTC);

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      sw_m <= 2'b00;
      sw_s <= 2'b00;
    end else begin
      sw_m <= switch_in;
      sw_s <= sw_m;
    end
  end

  // The button read clears only the flag whose code the firmware actually saw
  assign eventos = {fin_crono, alarma, botones_in};
  assign limpiar = {lee_est, lee_est,
                    lee_bot ? boton_de_codigo(8'(bus.in_port)) : 4'b0000};

  for (genvar i = 0; i < N_BANDERAS; i++) begin : g_bandera
    bandera_pegajosa u_bandera (
      .reloj   (reloj),
      .resetM  (resetM),
      .senal   (eventos[i]),
      .limpiar (limpiar[i]),
      .bandera (banderas[i]),
      .flanco  (flancos[i])
    );
  end

  // A new byte arriving with the clearing read of 0x31 is not an overrun
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      rtc_buf   <= '0;
      rtc_valid <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (rtc_listo) begin
        rtc_buf <= dato_rtc;
      end
      if (rtc_listo) begin
        rtc_valid <= 1'b1;
      end else if (lee_rtc) begin
        rtc_valid <= 1'b0;
      end
      if (rtc_listo && rtc_valid && !lee_rtc) begin
        ovr <= 1'b1;
      end else if (lee_est) begin
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    lectura = '0;
    case (dir)
      PUERTO_SWITCH:  lectura = ANCHO_DATO'({6'b0, sw_s});
      PUERTO_BOTONES: lectura = ANCHO_DATO'(codigo_boton(banderas[N_BOTONES-1:0]));
      PUERTO_ESTADO:  lectura = ANCHO_DATO'({4'b0, rtc_valid, ovr,
                                             banderas[IDX_ALARMA], banderas[IDX_CRONO]});
      PUERTO_RTC:     lectura = rtc_buf;
      default:        lectura = '0;
    endcase
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      bus.in_port <= '0;
    end else begin
      bus.in_port <= lectura;
    end
  end

  // Buttons are masked out: firmware polls them instead
  assign irq_evento = (|(flancos & MASCARA_IRQ)) | rtc_listo;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      estado <= INACTIVO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      INACTIVO: begin
        if (irq_evento) begin
          estado_sig = PENDIENTE;
        end
      end
      PENDIENTE: begin
        if (bus.interrupt_ack && !irq_evento) begin
          estado_sig = INACTIVO;
        end
      end
      default: estado_sig = INACTIVO;
    endcase
  end

  assign bus.interrupt = (estado == PENDIENTE);

endmodule

// File: tb/tb_mux_lectura_puertos.sv
// tb/tb_mux_lectura_puertos.sv - self-checking bench for mux_lectura_puertos
module tb_mux_lectura_puertos;

  logic       reloj;
  logic       resetM;
  logic [3:0] botones_in;
  logic [1:0] switch_in;
  logic       alarma;
  logic       fin_crono;
  logic [7:0] dato_rtc;
  logic       rtc_listo;

  int errores = 0;
  int checks  = 0;

  mux_lectura_puertos_if #(.ANCHO_DATO(8)) bus ();

  mux_lectura_puertos #(.ANCHO_DATO(8)) dut (
    .reloj      (reloj),
    .resetM     (resetM),
    .bus        (bus),
    .botones_in (botones_in),
    .switch_in  (switch_in),
    .alarma     (alarma),
    .fin_crono  (fin_crono),
    .dato_rtc   (dato_rtc),
    .rtc_listo  (rtc_listo)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic comprobar(input string nombre, input logic [7:0] actual, input logic [7:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errores++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nombre, actual, esperado, $time);
    end
  endtask

  // Reference model: register-level view of what the firmware should observe
  bit   [3:0] m_bot = '0;
  bit   [3:0] m_bot_prev = '0;
  bit         m_alm = 0, m_cro = 0, m_valid = 0, m_ovr = 0, m_irq = 0;
  bit   [7:0] m_buf = '0;
  bit   [1:0] m_sw_pipe [2] = '{2'b00, 2'b00};
  bit   [7:0] m_in_port = '0;

  task automatic modelo_paso();
    bit [7:0] nuevo;
    int       borrar;
    bit       rd22, rd30, rd31, hallado;
    rd22 = bus.read_strobe && bus.port_id == 8'h22;
    rd30 = bus.read_strobe && bus.port_id == 8'h30;
    rd31 = bus.read_strobe && bus.port_id == 8'h31;
    nuevo = 8'h00;
    case (bus.port_id)
      8'h01: nuevo = {6'b0, m_sw_pipe[1]};
      8'h22: begin
        hallado = 0;
        for (int i = 3; i >= 0; i--) begin
          if (!hallado && m_bot[i]) begin
            nuevo = 8'(4 - i);
            hallado = 1;
          end
        end
      end
      8'h30: nuevo = {4'b0, m_valid, m_ovr, m_alm, m_cro};
      8'h31: nuevo = m_buf;
      default: nuevo = 8'h00;
    endcase
    borrar = -1;
    if (rd22 && m_in_port >= 8'd1 && m_in_port <= 8'd4) borrar = 4 - int'(m_in_port);
    for (int i = 0; i < 4; i++) begin
      if (botones_in[i] && !m_bot_prev[i]) m_bot[i] = 1;
      else if (i == borrar) m_bot[i] = 0;
    end
    m_bot_prev = botones_in;
    if (alarma) m_alm = 1; else if (rd30) m_alm = 0;
    if (fin_crono) m_cro = 1; else if (rd30) m_cro = 0;
    if (rtc_listo && m_valid && !rd31) m_ovr = 1; else if (rd30) m_ovr = 0;
    if (rtc_listo) begin
      m_valid = 1;
      m_buf = dato_rtc;
    end else if (rd31) begin
      m_valid = 0;
    end
    if (alarma || fin_crono || rtc_listo) m_irq = 1;
    else if (bus.interrupt_ack) m_irq = 0;
    m_sw_pipe[1] = m_sw_pipe[0];
    m_sw_pipe[0] = switch_in;
    m_in_port = nuevo;
  endtask

  always @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      m_bot = '0; m_bot_prev = '0; m_alm = 0; m_cro = 0; m_valid = 0; m_ovr = 0;
      m_irq = 0; m_buf = '0; m_sw_pipe[0] = '0; m_sw_pipe[1] = '0; m_in_port = '0;
    end else begin
      modelo_paso();
    end
  end

  always begin
    @(posedge reloj);
    #3;
    comprobar("model_in_port", bus.in_port, m_in_port);
    comprobar("model_interrupt", {7'b0, bus.interrupt}, {7'b0, m_irq});
  end

  task automatic leer(input logic [7:0] dir, input logic [7:0] esp, input string nombre);
    @(negedge reloj);
    bus.port_id = dir;
    bus.read_strobe = 1'b0;
    @(negedge reloj);
    comprobar(nombre, bus.in_port, esp);
    bus.read_strobe = 1'b1;
    @(negedge reloj);
    bus.read_strobe = 1'b0;
  endtask

  task automatic ack_pulso();
    @(negedge reloj);
    bus.interrupt_ack = 1'b1;
    @(negedge reloj);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    bit visto;
    resetM = 1'b0;
    botones_in = '0; switch_in = '0; alarma = 0; fin_crono = 0; dato_rtc = '0; rtc_listo = 0;
    bus.port_id = 8'h00; bus.read_strobe = 0; bus.interrupt_ack = 0;
    repeat (2) @(negedge reloj);
    comprobar("reset_in_port", bus.in_port, 8'h00);
    comprobar("reset_interrupt", {7'b0, bus.interrupt}, 8'h00);
    resetM = 1'b1;

    @(negedge reloj);
    botones_in = 4'b1010;
    leer(8'h22, 8'h01, "bot_first_read");
    leer(8'h22, 8'h03, "bot_second_read");
    leer(8'h22, 8'h00, "bot_third_read");
    @(negedge reloj);
    botones_in = 4'b0000;

    @(negedge reloj);
    botones_in = 4'b0001;
    repeat (50) @(negedge reloj);
    leer(8'h22, 8'h04, "held_first_read");
    leer(8'h22, 8'h00, "held_second_read");
    botones_in = 4'b0000;

    @(negedge reloj);
    alarma = 1; botones_in = 4'b0100;
    @(negedge reloj);
    alarma = 0; bus.port_id = 8'h30;
    @(negedge reloj);
    comprobar("pre_reset_status", bus.in_port, 8'h02);
    @(negedge reloj);
    resetM = 1'b0;
    #1;
    comprobar("async_reset_in_port", bus.in_port, 8'h00);
    comprobar("async_reset_interrupt", {7'b0, bus.interrupt}, 8'h00);
    @(negedge reloj);
    botones_in = 4'b0000;
    resetM = 1'b1;
    leer(8'h30, 8'h00, "post_reset_status");

    @(negedge reloj);
    dato_rtc = 8'h5A; rtc_listo = 1;
    @(negedge reloj);
    rtc_listo = 0;
    @(negedge reloj);
    dato_rtc = 8'hA5; rtc_listo = 1;
    @(negedge reloj);
    rtc_listo = 0;
    leer(8'h30, 8'h0C, "rtc_status_overrun");
    leer(8'h31, 8'hA5, "rtc_data");
    leer(8'h30, 8'h00, "rtc_status_cleared");
    ack_pulso();
    comprobar("rtc_irq_acked", {7'b0, bus.interrupt}, 8'h00);

    @(negedge reloj);
    alarma = 1;
    @(negedge reloj);
    alarma = 0;
    comprobar("irq_rises", {7'b0, bus.interrupt}, 8'h01);
    @(negedge reloj);
    fin_crono = 1; bus.interrupt_ack = 1;
    @(negedge reloj);
    fin_crono = 0; bus.interrupt_ack = 0;
    comprobar("irq_event_beats_ack", {7'b0, bus.interrupt}, 8'h01);
    ack_pulso();
    comprobar("irq_falls", {7'b0, bus.interrupt}, 8'h00);
    leer(8'h30, 8'h03, "alm_cro_status");

    @(negedge reloj);
    bus.port_id = 8'h30;
    @(negedge reloj);
    comprobar("status_before_race", bus.in_port, 8'h00);
    bus.read_strobe = 1; alarma = 1;
    @(negedge reloj);
    bus.read_strobe = 0; alarma = 0;
    leer(8'h30, 8'h02, "alm_set_beats_clear");
    ack_pulso();

    @(negedge reloj);
    bus.port_id = 8'h01;
    @(negedge reloj);
    comprobar("switch_idle", bus.in_port, 8'h00);
    switch_in = 2'b10;
    visto = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge reloj);
      if (bus.in_port == 8'h02) visto = 1;
    end
    comprobar("switch_within_3", {7'b0, visto}, 8'h01);
    switch_in = 2'b00;

    @(negedge reloj);
    botones_in = 4'b0001;
    @(negedge reloj);
    botones_in = 4'b0000;
    leer(8'h7F, 8'h00, "unmapped_7f");
    leer(8'h10, 8'h00, "write_only_10");
    leer(8'h22, 8'h04, "bot_kept_after_unmapped");

    repeat (3) @(negedge reloj);
    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule

// File: doc/mux_lectura_puertos.md
# mux_lectura_puertos

Input-side port multiplexer for the PicoBlaze control processor; the read-direction counterpart of the output port decoder that latches `out_port` writes. Captures board events (buttons, alarm match, stopwatch done, RTC read data) into sticky flags and presents them on a registered `in_port` addressed by `port_id`. Flags clear on read. Raises `interrupt` with an ack handshake so firmware does not have to poll.

## Interface
Parameters:
- `ANCHO_DATO`, 8, width of `port_id`, `in_port`, `dato_rtc`

Ports:
- `reloj`  in  1  system clock, rising edge
- `resetM`  in  1  reset, asynchronous, active-low
- `port_id`  in  8  PicoBlaze port address
- `read_strobe`  in  1  PicoBlaze read strobe, one cycle per INPUT instruction
- `interrupt_ack`  in  1  PicoBlaze interrupt acknowledge, one-cycle pulse
- `botones_in`  in  4  debounced button levels, synchronous to `reloj`
- `switch_in`  in  2  board mode switches, asynchronous
- `alarma`  in  1  alarm-match pulse
- `fin_crono`  in  1  stopwatch-expired pulse
- `dato_rtc`  in  8  RTC read byte
- `rtc_listo`  in  1  `dato_rtc` valid, one-cycle pulse
- `in_port`  out  8  registered read data to PicoBlaze
- `interrupt`  out  1  interrupt request, level until acked

## Operation
- `switch_in` goes through a 2-flop synchronizer (`sw_s`).
- Buttons: a rising edge on `botones_in[i]` (vs. the previous-cycle register) sets sticky `bot_flag[i]`.
- `alarma` sets `alm_flag`; `fin_crono` sets `cro_flag`; `rtc_listo` loads `rtc_buf <= dato_rtc` and sets `rtc_valid`. `rtc_listo` while `rtc_valid=1` overwrites `rtc_buf` and sets `ovr`.
- Read map. `in_port` is recomputed every cycle from `port_id`:
  - 0x01: {6'b0, `sw_s`}
  - 0x22: button code, priority bit3 > bit0. `bot_flag[3]`→0x01, [2]→0x02, [1]→0x03, [0]→0x04, none→0x00. Same codes the writer side uses on port 0x22.
  - 0x30: {4'b0, `rtc_valid`, `ovr`, `alm_flag`, `cro_flag`}
  - 0x31: `rtc_buf`
  - any other address: 0x00
- Clear on read. These take effect at the edge where `read_strobe=1` and the address matches:
  - 0x22: clears only the bit named by the code currently in `in_port`.
  - 0x30: clears `alm_flag`, `cro_flag` and `ovr`.
  - 0x31: clears `rtc_valid`.
- Set beats clear: a new event in the same cycle as its clearing read leaves the flag at 1. For `rtc_buf`, the new data is loaded and `ovr` is not set.
- Interrupt FSM:
  - States: INACTIVO and PENDIENTE.
  - INACTIVO→PENDIENTE on a set event of `alm_flag`, `cro_flag` or `rtc_valid`.
  - PENDIENTE→INACTIVO on `interrupt_ack`.
  - An event in the same cycle as the ack leaves the FSM in PENDIENTE.
  - Button events do not interrupt; firmware polls port 0x22.
  - `interrupt` is 1 exactly when the FSM is in PENDIENTE.

## Timing
- Reset values: `in_port`=0x00, `interrupt`=0, all flags, `rtc_buf`, `sw_s` and edge registers =0. Reset may assert mid-operation; everything clears immediately.
- `in_port` latency is 1 cycle from `port_id`. PicoBlaze holds `port_id` for 2 cycles, so data is stable when `read_strobe` samples it.
- Flags become visible on `in_port` 2 cycles after the event: set edge, then register.
- `switch_in` reaches `in_port` in ≤3 cycles.
- `interrupt` rises 1 cycle after the triggering event and falls 1 cycle after `interrupt_ack`.
- With no strobe, flags hold indefinitely; there is no wrap or timeout.

## Structure
- Shared package holds:
  - port address constants: 0x01, 0x10, 0x11, 0x20, 0x21, 0x22, 0x30, 0x31. The writer-side decoder uses these too.
  - button code constants 0x01–0x04.
  - FSM state encoding.
- Sub-module `bandera_pegajosa`: edge detect, sticky set, clear-on-read, set-priority. Instantiated ×4 for buttons and reused for `alm_flag` and `cro_flag`.

## Test plan
- Reset mid-stream with flags set → all outputs 0x00/0 the same cycle; release, then read 0x30 → 0x00.
- `botones_in` rising on bits 3 and 1 together:
  - first read 0x22 → 0x01
  - second read → 0x03
  - third read → 0x00
- Button held high for 50 cycles → only one flag set.
- `rtc_listo` with 0x5A, then 0xA5 before any read:
  - read 0x30 → 0x0C
  - read 0x31 → 0xA5
  - read 0x30 → 0x00
- `alarma` pulse:
  - `interrupt`=1 next cycle.
  - `fin_crono` arriving in the same cycle as `interrupt_ack` → `interrupt` stays 1.
  - A second ack → `interrupt`=0.
  - Read 0x30 → 0x03.
- `alarma` in the same cycle as a strobed read of 0x30 → `alm_flag` stays set.
- `switch_in`=2'b10 → `in_port`=0x02 on port 0x01 within 3 cycles.
- Unmapped port 0x7F → 0x00.
